event_priority_controller: RTL and testbench
============================================

// Module: event_priority_controller
// PURPOSE
//  Captures rising edges on peripheral event lines into a pending mask and
//  presents the lowest-numbered pending event as a polled priority register.
//  An MCU read of that register retires the reported event and returns a
//  1-cycle read_ack pulse. read_ack is the MCU idle-loop poll indication
//  consumed by the MCU utilization counter.
// PARAMETERS
//  NUM_EVENTS  16        number of event inputs, 1..16; index 0 is the highest priority
//  IDLE_CODE   16'hFFFF  priority_out value when nothing is pending
// PORTS
//  sysclk         in   1           single system clock, all logic on its rising edge
//  sysreset       in   1           asynchronous, active-high reset
//  event_signals  in   NUM_EVENTS  event lines, already synchronous to sysclk
//  priority_read  in   1           1-cycle MCU read strobe of the priority register
//  clear_all      in   1           synchronous: discard all pending events
//  priority_out   out  16          index of highest-priority pending event, or IDLE_CODE
//  read_ack       out  1           1-cycle pulse, the cycle after a priority_read
//  pending_out    out  NUM_EVENTS  raw pending mask
//  overflow_out   out  NUM_EVENTS  present only with EVENT_OVERFLOW_EN
// BEHAVIOUR
//  - Reset (async):
//    - pending = 0, overflow = 0, read_ack = 0, priority_out = IDLE_CODE.
//    - event_prev = all ones, so a line already high at reset release raises no event.
//  - Edge detect: edge[k] = event_signals[k] & ~event_prev[k].
//    - event_prev is registered every cycle.
//    - pending[k] sets on the clock edge that ends the cycle where edge[k] is true.
//  - priority_out is registered as encode(pending): the lowest set index, zero-extended
//    to 16 bits, else IDLE_CODE.
//    - Input edge to pending_out: 1 cycle. Input edge to priority_out: 2 cycles.
//  - Read, in cycle N with priority_read = 1 and priority_out = k (not IDLE):
//    - At the end of N: pending[k] clears, read_ack <= 1, and priority_out <= IDLE_CODE
//      as a forced bubble.
//    - At the end of N+1: read_ack <= 0 and priority_out <= encode(pending).
//  - Read while priority_out = IDLE_CODE: nothing is cleared; read_ack still pulses.
//  - Back-to-back reads (N and N+1): the second read sees IDLE_CODE, so nothing is
//    cleared, and read_ack stays high for 2 cycles.
//  - Simultaneous events:
//    - Read-clear of k and a new edge on k in the same cycle: the set wins, so k stays
//      pending and the new event is not lost.
//    - clear_all has priority over everything. At the end of its cycle pending = 0,
//      overflow = 0, and priority_out = IDLE_CODE. Edges in that same cycle are discarded.
//    - clear_all and priority_read together: read_ack still pulses.
//  - Unused bits: indices >= NUM_EVENTS never assert. priority_out[15:4] is 0 unless
//    the value is IDLE_CODE.
//  - No wrap-around: each pending bit is saturating, so repeat edges on a set bit are merged.
// CONFIGURATION
//  EVENT_OVERFLOW_EN defined:
//    - overflow_out exists.
//    - overflow[k] sets when edge[k] occurs while pending[k] = 1 and the bit is not
//      being read-cleared in that cycle.
//    - overflow[k] clears only on sysreset or clear_all. It is sticky.
//  EVENT_OVERFLOW_EN undefined:
//    - overflow_out port and its logic are absent.
//    - Merged edges are silently lost. All other behaviour is identical.
// TESTING
//  1 Reset with event_signals = 16'h0001 held high -> priority_out = 16'hFFFF and
//    pending_out = 0 for 10 cycles. read_ack = 0.
//  2 Rising edges on lines 5 and 2 in the same cycle -> pending_out = 16'h0024 at +1 and
//    priority_out = 2 at +2. Read -> read_ack = 1, priority_out = FFFF, then 5 one cycle later.
//  3 Read of event 3 in the same cycle as a new edge on line 3 -> pending_out[3] stays 1.
//    priority_out returns to 3 after the bubble.
//  4 Reads on two consecutive cycles with one event (7) pending -> 7 is cleared once.
//    read_ack is high for 2 cycles and priority_out ends at 16'hFFFF.
//  5 clear_all with pending = 16'h8001 plus a new edge on line 4 -> pending_out = 0 and
//    priority_out = FFFF next cycle. Line 4 is not captured.
//  6 EVENT_OVERFLOW_EN: two edges on line 9 with no read between -> overflow_out = 16'h0200.
//    It holds through reads and clears on clear_all.

Source files
------------

// File: rtl/event_priority_if.sv
`default_nettype none
// ============================================================================
// Module : event_priority_if
// Brief  : MCU-facing bus of the event priority controller; the overflow_out
//          signal exists only when EVENT_OVERFLOW_EN is defined.
// Rev    : 1.0  initial release
// ============================================================================
interface event_priority_if #(
    parameter int NUM_EVENTS = 16
);
    logic [NUM_EVENTS-1:0] event_signals;
    logic                  priority_read;
    logic                  clear_all;
    logic [15:0]           priority_out;
    logic                  read_ack;
    logic [NUM_EVENTS-1:0] pending_out;
`ifdef EVENT_OVERFLOW_EN
    logic [NUM_EVENTS-1:0] overflow_out;

    modport master (
        output event_signals, priority_read, clear_all,
        input  priority_out, read_ack, pending_out, overflow_out
    );
    modport slave (
        input  event_signals, priority_read, clear_all,
        output priority_out, read_ack, pending_out, overflow_out
    );
`else
    modport master (
        output event_signals, priority_read, clear_all,
        input  priority_out, read_ack, pending_out
    );
    modport slave (
        input  event_signals, priority_read, clear_all,
        output priority_out, read_ack, pending_out
    );
`endif
endinterface
`default_nettype wire

// File: rtl/event_priority_controller.sv
`default_nettype none
// ============================================================================
// Module : event_priority_controller
// Brief  : Rising-edge event capture with a polled, read-to-retire priority
//          register. Optional sticky overflow flags under EVENT_OVERFLOW_EN.
// Rev    : 1.0  initial release
// ============================================================================
module event_priority_controller #(
    parameter int          NUM_EVENTS = 16,
    parameter logic [15:0] IDLE_CODE  = 16'hFFFF
) (
    input  wire logic         sysclk,
    input  wire logic         sysreset,
    event_priority_if.slave   bus
);
    logic [NUM_EVENTS-1:0] r_event_prev;
    logic [NUM_EVENTS-1:0] r_pending;
    logic [15:0]           r_priority;
    logic                  r_read_ack;

    logic [NUM_EVENTS-1:0] w_edge;
    logic [NUM_EVENTS-1:0] w_rd_clr;
    logic [15:0]           w_encode;
    logic                  w_read_hit;

    assign w_edge     = bus.event_signals & ~r_event_prev;
    assign w_read_hit = bus.priority_read && (r_priority != IDLE_CODE);

    // Scan high-to-low so the lowest set index is the last one written.
    always_comb begin
        w_encode = IDLE_CODE;
        for (int i = NUM_EVENTS - 1; i >= 0; i--) begin
            if (r_pending[i]) begin
                w_encode = 16'(i);
            end
        end
    end

    generate
        for (genvar k = 0; k < NUM_EVENTS; k++) begin : g_rd_clr
            assign w_rd_clr[k] = w_read_hit && (r_priority == 16'(k));
        end
    endgenerate

    // A new edge is ORed in after the read-clear so a coincident event survives.
    always_ff @(posedge sysclk or posedge sysreset) begin
        if (sysreset) begin
            r_event_prev <= '1;
            r_pending    <= '0;
            r_priority   <= IDLE_CODE;
            r_read_ack   <= 1'b0;
        end else begin
            r_event_prev <= bus.event_signals;
            r_read_ack   <= bus.priority_read;
            if (bus.clear_all) begin
                r_pending  <= '0;
                r_priority <= IDLE_CODE;
            end else begin
                r_pending  <= (r_pending & ~w_rd_clr) | w_edge;
                r_priority <= w_read_hit ? IDLE_CODE : w_encode;
            end
        end
    end

    assign bus.pending_out  = r_pending;
    assign bus.priority_out = r_priority;
    assign bus.read_ack     = r_read_ack;

`ifdef EVENT_OVERFLOW_EN
    logic [NUM_EVENTS-1:0] r_overflow;

    always_ff @(posedge sysclk or posedge sysreset) begin
        if (sysreset) begin
            r_overflow <= '0;
        end else if (bus.clear_all) begin
            r_overflow <= '0;
        end else begin
            r_overflow <= r_overflow | (w_edge & r_pending & ~w_rd_clr);
        end
    end

    assign bus.overflow_out = r_overflow;
`endif

endmodule
`default_nettype wire

// File: tb/tb_event_priority_controller.sv
`default_nettype none
// ============================================================================
// Module : tb_event_priority_controller
// Brief  : Directed scenarios plus random traffic against a behavioural model.
// Rev    : 1.0  initial release
// ============================================================================
module tb_event_priority_controller;
    localparam int NUM = 16;

    logic clk;
    logic rst;
    int   n_vec;
    int   n_err;

    event_priority_if #(.NUM_EVENTS(NUM)) bus ();

    event_priority_controller #(
        .NUM_EVENTS (NUM),
        .IDLE_CODE  (16'hFFFF)
    ) u_dut (
        .sysclk   (clk),
        .sysreset (rst),
        .bus      (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Behavioural model: per-line flags, priority as an int (-1 = idle).
    bit m_pend [NUM];
    bit m_ovf  [NUM];
    bit m_prev [NUM];
    int m_prio;
    bit m_ack;

    task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s : got %h expected %h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic int lowest();
        for (int i = 0; i < NUM; i++) begin
            if (m_pend[i]) return i;
        end
        return -1;
    endfunction

    function automatic logic [15:0] to_vec(input bit a [NUM]);
        logic [15:0] v;
        v = '0;
        for (int i = 0; i < NUM; i++) v[i] = a[i];
        return v;
    endfunction

    function automatic void model_reset();
        for (int i = 0; i < NUM; i++) begin
            m_pend[i] = 1'b0;
            m_ovf[i]  = 1'b0;
            m_prev[i] = 1'b1;
        end
        m_prio = -1;
        m_ack  = 1'b0;
    endfunction

    function automatic void model_clock(input logic [15:0] ev, input bit rd, input bit ca);
        int  hit;
        int  low;
        bit  e;
        hit = (rd && m_prio >= 0) ? m_prio : -1;
        low = lowest();
        for (int i = 0; i < NUM; i++) begin
            e = ev[i] && !m_prev[i];
            if (ca) begin
                m_pend[i] = 1'b0;
                m_ovf[i]  = 1'b0;
            end else begin
                if (e && m_pend[i] && i != hit) m_ovf[i] = 1'b1;
                if (e)             m_pend[i] = 1'b1;
                else if (i == hit) m_pend[i] = 1'b0;
            end
            m_prev[i] = ev[i];
        end
        m_prio = (ca || hit >= 0) ? -1 : low;
        m_ack  = rd;
    endfunction

    task automatic compare_all();
        check("pending", bus.pending_out, to_vec(m_pend));
        check("priority", bus.priority_out, (m_prio < 0) ? 16'hFFFF : 16'(m_prio));
        check("read_ack", {15'd0, bus.read_ack}, {15'd0, m_ack});
`ifdef EVENT_OVERFLOW_EN
        check("overflow", bus.overflow_out, to_vec(m_ovf));
`endif
    endtask

    task automatic step(input logic [15:0] ev, input bit rd, input bit ca);
        bus.event_signals = ev;
        bus.priority_read = rd;
        bus.clear_all     = ca;
        @(posedge clk);
        model_clock(ev, rd, ca);
        #2;
        compare_all();
    endtask

    logic [15:0] r_ev;

    initial begin
        n_vec = 0;
        n_err = 0;
        rst = 1'b1;
        bus.event_signals = 16'h0001;
        bus.priority_read = 1'b0;
        bus.clear_all     = 1'b0;
        model_reset();
        #23;
        rst = 1'b0;
        check("rst_pending", bus.pending_out, 16'h0000);
        check("rst_priority", bus.priority_out, 16'hFFFF);
        check("rst_ack", {15'd0, bus.read_ack}, 16'h0000);

        // Line 0 high across reset release: no event.
        for (int i = 0; i < 10; i++) step(16'h0001, 0, 0);
        check("t1_priority", bus.priority_out, 16'hFFFF);

        // Two simultaneous edges, then read retires the lower index.
        step(16'h0025, 0, 0);
        check("t2_pending", bus.pending_out, 16'h0024);
        step(16'h0025, 0, 0);
        check("t2_prio2", bus.priority_out, 16'h0002);
        step(16'h0025, 1, 0);
        check("t2_ack", {15'd0, bus.read_ack}, 16'h0001);
        check("t2_bubble", bus.priority_out, 16'hFFFF);
        step(16'h0025, 0, 0);
        check("t2_prio5", bus.priority_out, 16'h0005);
        step(16'h0025, 1, 0);
        step(16'h0001, 0, 0);
        check("t2_empty", bus.pending_out, 16'h0000);

        // Read-clear of 3 coinciding with a fresh edge on 3.
        step(16'h0009, 0, 0);
        step(16'h0001, 0, 0);
        check("t3_prio3", bus.priority_out, 16'h0003);
        step(16'h0009, 1, 0);
        check("t3_kept", bus.pending_out, 16'h0008);
        step(16'h0009, 0, 0);
        check("t3_prio_back", bus.priority_out, 16'h0003);
        step(16'h0009, 1, 0);
        step(16'h0009, 0, 0);

        // Back-to-back reads with a single pending event.
        step(16'h0089, 0, 0);
        step(16'h0089, 0, 0);
        check("t4_prio7", bus.priority_out, 16'h0007);
        step(16'h0089, 1, 0);
        step(16'h0089, 1, 0);
        check("t4_ack2", {15'd0, bus.read_ack}, 16'h0001);
        check("t4_pending", bus.pending_out, 16'h0000);
        step(16'h0089, 0, 0);
        check("t4_ack_low", {15'd0, bus.read_ack}, 16'h0000);
        check("t4_idle", bus.priority_out, 16'hFFFF);

        // clear_all beats a coincident edge on line 4.
        step(16'h0000, 0, 0);
        step(16'h8001, 0, 0);
        check("t5_pending", bus.pending_out, 16'h8001);
        step(16'h8011, 1, 1);
        check("t5_cleared", bus.pending_out, 16'h0000);
        check("t5_idle", bus.priority_out, 16'hFFFF);
        check("t5_ack", {15'd0, bus.read_ack}, 16'h0001);
        step(16'h8011, 0, 0);
        check("t5_no_line4", bus.pending_out, 16'h0000);

`ifdef EVENT_OVERFLOW_EN
        step(16'h0000, 0, 0);
        step(16'h0200, 0, 0);
        step(16'h0000, 0, 0);
        step(16'h0200, 0, 0);
        check("t6_ovf", bus.overflow_out, 16'h0200);
        step(16'h0200, 1, 0);
        step(16'h0200, 0, 0);
        check("t6_ovf_hold", bus.overflow_out, 16'h0200);
        step(16'h0000, 0, 1);
        check("t6_ovf_clr", bus.overflow_out, 16'h0000);
`endif

        // Random traffic: sparse line toggles, frequent reads, rare clear_all.
        r_ev = 16'h0000;
        for (int i = 0; i < 600; i++) begin
            r_ev = r_ev ^ (16'($urandom) & 16'($urandom) & 16'($urandom));
            step(r_ev, ($urandom_range(0, 2) == 0), ($urandom_range(0, 40) == 0));
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
`default_nettype wire
